psum_accumulator: RTL and testbench
===================================

// Module: psum_accumulator
// PURPOSE
//  Downstream of the PE engine. Takes the per-pixel Tout-lane partial sums emitted by conv_pe
//  (o_acc/o_vld plus the pipelined row/col) and accumulates them across input-channel tiles in an
//  internal partial-sum RAM (read-modify-write). On the last input-channel tile it streams the
//  final sums to the output/quantise stage and flags end of frame.
// PARAMETERS
//  Tout     4     output-channel lanes per beat
//  W_PSUM   32    signed width of one lane (input, stored, and output)
//  W_SIZE   9     row/col/width/height field width
//  DEPTH    4096  pixel entries in psum RAM; each entry holds Tout*W_PSUM bits
//  AW       12    RAM address width, clog2(DEPTH)
// PORTS
//  clk           in   1             clock
//  rstn          in   1             async active-low reset
//  i_vld         in   1             one pixel beat of partial sums valid this cycle (no backpressure)
//  i_acc_flat    in   Tout*W_PSUM   lane g at [(g+1)*W_PSUM-1 -: W_PSUM], signed
//  i_row         in   W_SIZE        pixel row of this beat
//  i_col         in   W_SIZE        pixel column of this beat
//  i_first_tile  in   1             first input-channel tile: overwrite, do not add stored value
//  i_last_tile   in   1             last input-channel tile: emit result on output
//  i_width       in   W_SIZE        frame width in pixels; static while i_vld can be high
//  i_height      in   W_SIZE        frame height in pixels; static while i_vld can be high
//  o_vld         out  1             final sum beat valid
//  o_data_flat   out  Tout*W_PSUM   final sums, same lane packing as input
//  o_addr        out  AW            pixel index of o_data_flat (row*i_width+col)
//  o_frame_done  out  1             1-cycle pulse with the final beat of a frame
//  o_err         out  1             sticky: an out-of-range beat was dropped
// BEHAVIOUR
//  - Reset: o_vld=0, o_data_flat=0, o_addr=0, o_frame_done=0, o_err=0, pipe valids=0, out count=0.
//    RAM contents are not reset; the first tile always overwrites them.
//  - addr = i_row*i_width + i_col, computed combinationally in S0.
//    Out of range (i_row>=i_height, i_col>=i_width, or addr>=DEPTH): beat dropped, no RAM write,
//    no output, and o_err set until reset.
//  - 3-stage pipeline, one beat per cycle, no stalls:
//    S0 (edge t): register addr/acc/flags; issue synchronous RAM read.
//    S1 (edge t+1): read data valid; select the operand.
//    S2 (edge t+2): sum registered; RAM write; o_vld/o_data_flat/o_addr updated.
//    Latency i_vld -> o_vld is 2 cycles.
//  - Operand select in S1:
//    i_first_tile -> 0.
//    Otherwise forward the newest match, in priority order:
//      1. the S2 entry being written this cycle, same addr;
//      2. the entry written on the previous edge, same addr;
//      3. else RAM read data.
//    Back-to-back and every-other-cycle beats to the same pixel must accumulate exactly.
//  - Arithmetic: per lane, signed add of W_PSUM+1 bits, saturated to W_PSUM.
//    Clamp to 0x7FFF_FFFF / 0x8000_0000 at the default width. Lanes are independent.
//  - RAM is always written with the saturated sum, including on the last tile.
//  - o_vld is high for 1 cycle per S2 beat with last_tile=1, and low for non-last tiles.
//  - Frame counter counts emitted beats.
//    When count reaches i_width*i_height: o_frame_done pulses with that beat and the counter wraps to 0.
//  - Simultaneous i_vld on consecutive cycles is the normal case; there are no idle-cycle requirements.
//  - rstn asserted mid-operation: in-flight beats are discarded and no output is produced for them.
// TESTING
//  1. 4x4 frame, 1 tile (first=last=1), lane g = row*4+col+g
//     -> 16 o_vld beats, o_addr 0..15, data equals input, o_frame_done on the 16th beat only.
//  2. 4x4, 3 tiles, acc lanes = 1,2,3,4 each tile
//     -> tiles 1-2 give no o_vld; tile 3 outputs 3,6,9,12 at every addr, with 2-cycle latency.
//  3. Same pixel (2,1) beats on 3 consecutive cycles (first, mid, last), lane0 = 5,7,11
//     -> single o_vld with lane0 = 23 (forwarding paths 1 and 2).
//  4. Lane0 first = 0x7FFF_FFF0, last = 0x20 -> 0x7FFF_FFFF.
//     Lane1 first = 0x8000_0010, last = -0x20 -> 0x8000_0000.
//  5. i_col=4 with i_width=4 -> no o_vld, RAM untouched, o_err=1 and held.
//     The following valid beats are processed normally.
//  6. rstn pulsed 1 cycle after a last-tile i_vld
//     -> no o_vld; all outputs 0; next frame runs as in test 1.

Source files
------------

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator downstream of the PE engine. Each input beat carries
// Tout signed lane partial sums for one pixel. The block adds them to the value
// held in an internal partial-sum RAM for the same pixel (read-modify-write),
// saturating per lane, and on the last input-channel tile streams the final
// sums out together with the pixel index and an end-of-frame pulse.
//
// Handshake: i_vld / o_vld are valid-only strobes with no ready and no
// backpressure. A beat is consumed on every rising edge where i_vld is high.
// A result is presented for exactly the one cycle o_vld is high, and the
// downstream stage must take it in that cycle.
//
// Pipeline (one beat per cycle, never stalls):
//   S0 edge: register addr/acc/flags, launch the synchronous RAM read
//   S1 edge: choose the operand (0 / forwarded sum / RAM data), register it
//   S2 edge: register the saturated sum, write RAM, drive outputs
module psum_accumulator #(
  parameter int Tout   = 4,
  parameter int W_PSUM = 32,
  parameter int W_SIZE = 9,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_vld,
  input  logic [Tout*W_PSUM-1:0]   i_acc_flat,
  input  logic [W_SIZE-1:0]        i_row,
  input  logic [W_SIZE-1:0]        i_col,
  input  logic                     i_first_tile,
  input  logic                     i_last_tile,
  input  logic [W_SIZE-1:0]        i_width,
  input  logic [W_SIZE-1:0]        i_height,
  output logic                     o_vld,
  output logic [Tout*W_PSUM-1:0]   o_data_flat,
  output logic [AW-1:0]            o_addr,
  output logic                     o_frame_done,
  output logic                     o_err
);

  localparam int LW = Tout * W_PSUM;
  localparam int PW = 2 * W_SIZE;

  // Signed add of two lanes with one guard bit, clamped to the lane range.
  function automatic logic [W_PSUM-1:0] sat_add(input logic [W_PSUM-1:0] a,
                                                input logic [W_PSUM-1:0] b);
    logic [W_PSUM:0] wide;
    wide = {a[W_PSUM-1], a} + {b[W_PSUM-1], b};
    if (wide[W_PSUM] != wide[W_PSUM-1]) begin
      sat_add = wide[W_PSUM] ? {1'b1, {(W_PSUM-1){1'b0}}}
                             : {1'b0, {(W_PSUM-1){1'b1}}};
    end else begin
      sat_add = wide[W_PSUM-1:0];
    end
  endfunction

  // ---------------- S0: address generation and range check ----------------
  logic [PW-1:0] row_base;
  logic [PW:0]   addr_full;
  logic          in_range;

  assign row_base  = PW'(i_row) * PW'(i_width);
  assign addr_full = {1'b0, row_base} + (PW+1)'(i_col);
  assign in_range  = (i_row < i_height) && (i_col < i_width) &&
                     (addr_full < (PW+1)'(DEPTH));

  // ---------------- pipeline registers ----------------
  logic              s1_vld_q, s1_first_q, s1_last_q;
  logic [AW-1:0]     s1_addr_q;
  logic [LW-1:0]     s1_acc_q;
  logic [LW-1:0]     rd_data_q;

  logic              s2_vld_q, s2_last_q;
  logic [AW-1:0]     s2_addr_q;
  logic [LW-1:0]     s2_acc_q, s2_op_q;

  // Copy of the RAM write committed on the most recent edge. The RAM read
  // issued on that same edge returns the old contents, so this covers it.
  logic              w_vld_q;
  logic [AW-1:0]     w_addr_q;
  logic [LW-1:0]     w_data_q;

  logic [PW-1:0]     cnt_q;
  logic              err_q;

  logic [LW-1:0]     mem_q [DEPTH];

  logic [LW-1:0]     sum_d;
  logic [LW-1:0]     op_d;
  logic [PW-1:0]     cnt_inc;
  logic [PW-1:0]     frame_total;

  assign cnt_inc     = cnt_q + PW'(1);
  assign frame_total = PW'(i_width) * PW'(i_height);
  assign o_err       = err_q;

  // Per-lane saturated sum of the S2 operand and the incoming partial sum.
  always_comb begin
    sum_d = '0;
    for (int g = 0; g < Tout; g++) begin
      sum_d[g*W_PSUM +: W_PSUM] = sat_add(s2_op_q[g*W_PSUM +: W_PSUM],
                                          s2_acc_q[g*W_PSUM +: W_PSUM]);
    end
  end

  // Operand select: first tile starts from zero, otherwise the newest value
  // for this pixel wins (sum about to be written, then last write, then RAM).
  always_comb begin
    op_d = rd_data_q;
    if (s1_first_q) begin
      op_d = '0;
    end else if (s2_vld_q && (s2_addr_q == s1_addr_q)) begin
      op_d = sum_d;
    end else if (w_vld_q && (w_addr_q == s1_addr_q)) begin
      op_d = w_data_q;
    end
  end

  // Partial-sum RAM: synchronous read at S0, write of the saturated sum at S2.
  always_ff @(posedge clk) begin
    if (s2_vld_q) begin
      mem_q[s2_addr_q] <= sum_d;
    end
    rd_data_q <= mem_q[addr_full[AW-1:0]];
  end

  // Stage S0 -> S1 capture; out-of-range beats are dropped and flag o_err.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_acc_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_vld_q   <= i_vld && in_range;
      s1_first_q <= i_first_tile;
      s1_last_q  <= i_last_tile;
      s1_addr_q  <= addr_full[AW-1:0];
      s1_acc_q   <= i_acc_flat;
      if (i_vld && !in_range) begin
        err_q <= 1'b1;
      end
    end
  end

  // Stage S1 -> S2 capture with the forwarded operand.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_addr_q <= '0;
      s2_acc_q  <= '0;
      s2_op_q   <= '0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_addr_q <= s1_addr_q;
      s2_acc_q  <= s1_acc_q;
      s2_op_q   <= op_d;
    end
  end

  // Stage S2: record the committed write for forwarding, emit final sums.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_vld_q      <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      o_vld        <= 1'b0;
      o_data_flat  <= '0;
      o_addr       <= '0;
      o_frame_done <= 1'b0;
      cnt_q        <= '0;
    end else begin
      w_vld_q      <= s2_vld_q;
      w_addr_q     <= s2_addr_q;
      w_data_q     <= sum_d;
      o_vld        <= 1'b0;
      o_frame_done <= 1'b0;
      if (s2_vld_q && s2_last_q) begin
        o_vld       <= 1'b1;
        o_data_flat <= sum_d;
        o_addr      <= s2_addr_q;
        if (cnt_inc == frame_total) begin
          o_frame_done <= 1'b1;
          cnt_q        <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: a per-pixel array model of the accumulated
// partial sums predicts every final beat; a negedge monitor pops and compares.
module tb_psum_accumulator;

  localparam int TOUT = 4;
  localparam int WP   = 32;
  localparam int WS   = 9;
  localparam int AW   = 12;
  localparam int LW   = TOUT * WP;
  localparam int EW   = 1 + AW + LW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic          i_vld;
  logic [LW-1:0] i_acc_flat;
  logic [WS-1:0] i_row, i_col, i_width, i_height;
  logic          i_first_tile, i_last_tile;
  logic          o_vld, o_frame_done, o_err;
  logic [LW-1:0] o_data_flat;
  logic [AW-1:0] o_addr;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  psum_accumulator dut (
    .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_acc_flat(i_acc_flat),
    .i_row(i_row), .i_col(i_col), .i_first_tile(i_first_tile),
    .i_last_tile(i_last_tile), .i_width(i_width), .i_height(i_height),
    .o_vld(o_vld), .o_data_flat(o_data_flat), .o_addr(o_addr),
    .o_frame_done(o_frame_done), .o_err(o_err)
  );

  // ---------------- scoreboard and reference model ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            checks = 0;
  int            errors = 0;

  int mem_m [4096][TOUT];  // accumulated value per pixel and lane
  int emitted = 0;         // final beats emitted in the current frame
  int fw = 4, fh = 4;

  task automatic check_val(input string name, input logic [159:0] act,
                           input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input longint s);
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return int'(s);
  endfunction

  function automatic logic [LW-1:0] pack(input int l0, input int l1,
                                         input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  // Monitor: every output beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (o_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_o_vld actual addr=%0d required no beat", o_addr);
        end else begin
          check_val("out_beat", {o_frame_done, o_addr, o_data_flat}, exp_q.pop_front());
          check_val("out_latency", cyc, exp_cyc_q.pop_front());
        end
      end else if (o_frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done_without_vld actual=1 required=0");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_frame(input int w, input int h);
    fw = w;
    fh = h;
    i_width  = WS'(w);
    i_height = WS'(h);
  endtask

  // Issue one beat and update the model the way the specification describes.
  task automatic send(input int row, input int col, input bit first,
                      input bit last, input logic [LW-1:0] acc);
    int            idx;
    logic [LW-1:0] res;
    bit            done;
    i_vld        = 1'b1;
    i_row        = WS'(row);
    i_col        = WS'(col);
    i_first_tile = first;
    i_last_tile  = last;
    i_acc_flat   = acc;
    idx = row * fw + col;
    if (row < fh && col < fw && idx < 4096) begin
      for (int g = 0; g < TOUT; g++) begin
        longint cur;
        cur = first ? 0 : longint'(mem_m[idx][g]);
        mem_m[idx][g] = sat(cur + longint'($signed(acc[g*WP +: WP])));
        res[g*WP +: WP] = mem_m[idx][g];
      end
      if (last) begin
        emitted++;
        done = (emitted == fw * fh);
        if (done) emitted = 0;
        exp_q.push_back({done, AW'(idx), res});
        exp_cyc_q.push_back(cyc + 3);
      end
    end
    @(posedge clk);
    #1;
    i_vld = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_o_vld"}, o_vld, 0);
    check_val({tag, "_o_data"}, o_data_flat, 0);
    check_val({tag, "_o_addr"}, o_addr, 0);
    check_val({tag, "_o_frame_done"}, o_frame_done, 0);
    check_val({tag, "_o_err"}, o_err, 0);
  endtask

  task automatic frame_one_tile();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send(r, c, 1'b1, 1'b1, pack(r*4+c, r*4+c+1, r*4+c+2, r*4+c+3));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    rstn = 1'b0;
    i_vld = 1'b0;
    i_acc_flat = '0;
    i_row = '0;
    i_col = '0;
    i_first_tile = 1'b0;
    i_last_tile = 1'b0;
    set_frame(4, 4);
    idle(3);
    check_outputs_zero("reset");
    rstn = 1'b1;
    idle(2);

    // 1: single-tile 4x4 frame, data passes through unchanged
    frame_one_tile();
    idle(4);

    // 2: three tiles of 1,2,3,4 -> 3,6,9,12 on the last tile only
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          send(r, c, t == 0, t == 2, pack(1, 2, 3, 4));
    idle(4);

    // 3: same pixel back-to-back, every other cycle, and every third cycle
    for (int gap = 0; gap < 3; gap++) begin
      send(2, 1, 1'b1, 1'b0, pack(5, 0, 0, 0));
      idle(gap);
      send(2, 1, 1'b0, 1'b0, pack(7, 0, 0, 0));
      idle(gap);
      send(2, 1, 1'b0, 1'b1, pack(11, 0, 0, 0));
      idle(4);
    end

    // 4: saturation at both ends of the lane range
    send(3, 3, 1'b1, 1'b0, pack(32'h7FFF_FFF0, 32'h8000_0010, 3, -3));
    send(3, 3, 1'b0, 1'b1, pack(32'h20, -32'h20, 4, -4));
    idle(4);

    // 5: out-of-range beats are dropped, leave RAM alone and latch o_err
    check_val("err_clear", o_err, 0);
    send(1, 0, 1'b1, 1'b0, pack(100, 200, 300, 400));
    send(0, 4, 1'b1, 1'b1, pack(999, 999, 999, 999));
    check_val("err_set", o_err, 1);
    send(4, 0, 1'b1, 1'b1, pack(999, 999, 999, 999));
    send(1, 0, 1'b0, 1'b1, pack(1, 1, 1, 1));
    idle(4);
    check_val("err_held", o_err, 1);

    // 6: reset one cycle after a last-tile beat discards it
    i_vld = 1'b1;
    i_row = '0;
    i_col = '0;
    i_first_tile = 1'b1;
    i_last_tile = 1'b1;
    i_acc_flat = pack(77, 77, 77, 77);
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero("midreset");
    rstn = 1'b1;
    emitted = 0;
    idle(4);
    frame_one_tile();
    idle(4);

    // Random frames: random size and tile count, random gaps, plus a burst
    // of accumulations onto one pixel per frame.
    for (int f = 0; f < 6; f++) begin
      int tiles, pr, pc, n;
      set_frame($urandom_range(2, 6), $urandom_range(2, 6));
      tiles = $urandom_range(1, 3);
      for (int t = 0; t < tiles; t++)
        for (int r = 0; r < fh; r++)
          for (int c = 0; c < fw; c++) begin
            if ($urandom_range(0, 1) == 0)
              send(r, c, t == 0, t == tiles - 1, pack($urandom, $urandom, $urandom, $urandom));
            else
              send(r, c, t == 0, t == tiles - 1,
                   pack($urandom_range(0, 1000) - 500, $urandom_range(0, 1000) - 500,
                        $urandom_range(0, 1000) - 500, $urandom_range(0, 1000) - 500));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          end
      pr = $urandom_range(0, fh - 1);
      pc = $urandom_range(0, fw - 1);
      n  = $urandom_range(1, 4);
      send(pr, pc, 1'b1, 1'b0, pack($urandom_range(0, 99), -7, 1, $urandom));
      for (int k = 0; k < n; k++) begin
        idle($urandom_range(0, 2));
        send(pr, pc, 1'b0, k == n - 1,
             pack($urandom_range(0, 99), $urandom_range(0, 99), -2, $urandom));
      end
      idle(3);
    end

    // Drain with a bounded wait, then confirm nothing is left outstanding.
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    idle(3);
    check_val("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
